// File: rtl/gfg_pkg.sv
// gfg_pkg: shared definitions for gate_fault_guard.
//   - run state encoding, fault cause codes, gate vector bit positions
//   - shoot_through(): any phase with high and low side on together
package gfg_pkg;

  localparam int unsigned GATE_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_FAULT    = 2'd2,
    ST_COOLDOWN = 2'd3
  } gfg_state_e;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_EXT  = 2'd1;
  localparam logic [1:0] FC_ST   = 2'd2;
  localparam logic [1:0] FC_BOTH = 2'd3;

  localparam int unsigned PH_AH = 5;
  localparam int unsigned PH_AL = 4;
  localparam int unsigned PH_BH = 3;
  localparam int unsigned PH_BL = 2;
  localparam int unsigned PH_CH = 1;
  localparam int unsigned PH_CL = 0;

  function automatic logic shoot_through(input logic [GATE_W-1:0] g);
    return (g[PH_AH] & g[PH_AL]) | (g[PH_BH] & g[PH_BL]) | (g[PH_CH] & g[PH_CL]);
  endfunction

endpackage

// File: rtl/gfg_min_pulse.sv
// gfg_min_pulse: turn-on delay for one gate line (built only with GFG_MIN_PULSE_EN).
//   clk, rst_n : clock, async active-low reset
//   d          : registered gate line
//   min_pulse  : cycles d must already have been high before q_c rises
//   q_c        : filtered line (combinational); falls together with d
`ifdef GFG_MIN_PULSE_EN
module gfg_min_pulse #(
  parameter int unsigned MINP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              d,
  input  logic [MINP_W-1:0] min_pulse,
  output logic              q_c
);

  logic [MINP_W-1:0] high_cnt_q;

  // Length of the current high run of d, saturating so long pulses stay on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_cnt_q <= '0;
    end else if (!d) begin
      high_cnt_q <= '0;
    end else if (high_cnt_q != '1) begin
      high_cnt_q <= high_cnt_q + MINP_W'(1);
    end
  end

  assign q_c = d && (high_cnt_q >= min_pulse);

endmodule
`endif

// File: rtl/gate_fault_guard.sv
// gate_fault_guard: protection stage between deadtime driver and gate pins.
// Forwards {AH,AL,BH,BL,CH,CL} only in RUN; forces all gates off on
// shoot-through or filtered external fault, latches the cause until clear,
// then waits a restart holdoff.
// Optional feature: define GFG_MIN_PULSE_EN for the per-line turn-on filter.
// Ports:
//   clk, rst_n    : clock, async active-low reset
//   enable        : run request
//   gate_in[5:0]  : gates from deadtime driver (bit 5 = AH)
//   fault_n       : external overcurrent, active-low, asynchronous
//   fault_filt    : consecutive low samples to accept fault (0 acts as 1)
//   holdoff       : cooldown length in cycles
//   min_pulse     : minimum on-time (ignored without GFG_MIN_PULSE_EN)
//   clear         : fault acknowledge
//   gate_out      : protected gates
//   state         : IDLE/RUN/FAULT/COOLDOWN
//   fault_code    : latched cause (1 ext, 2 shoot-through, 3 both)
//   run           : state is RUN
module gate_fault_guard
  import gfg_pkg::*;
#(
  parameter int unsigned FILT_W = 4,
  parameter int unsigned HOLD_W = 16,
  parameter int unsigned MINP_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [5:0]        gate_in,
  input  logic              fault_n,
  input  logic [FILT_W-1:0] fault_filt,
  input  logic [HOLD_W-1:0] holdoff,
  input  logic [MINP_W-1:0] min_pulse,
  input  logic              clear,
  output logic [5:0]        gate_out,
  output logic [1:0]        state,
  output logic [1:0]        fault_code,
  output logic              run
);

  gfg_state_e        state_q, state_d;
  logic [GATE_W-1:0] gin_q, gate_f_c, gate_d;
  logic              sync1_q, sync2_q;
  logic [FILT_W-1:0] filt_cnt_q, filt_thr_c;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              st_flt, ext_flt, fault_c;
  logic [1:0]        code_d;
  logic              run_d;

  // Gate capture and fault_n synchronizer (idle level is "no fault").
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gin_q   <= '0;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      gin_q   <= gate_in;
      sync1_q <= fault_n;
      sync2_q <= sync1_q;
    end
  end

  // Consecutive-low filter on the synchronized fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_q <= '0;
    end else if (sync2_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q != '1) begin
      filt_cnt_q <= filt_cnt_q + FILT_W'(1);
    end
  end

  assign filt_thr_c = (fault_filt == '0) ? FILT_W'(1) : fault_filt;
  assign ext_flt    = (filt_cnt_q >= filt_thr_c);
  assign st_flt     = shoot_through(gin_q);
  assign fault_c    = st_flt | ext_flt;

`ifdef GFG_MIN_PULSE_EN
  for (genvar i = 0; i < GATE_W; i++) begin : g_min_pulse
    gfg_min_pulse #(.MINP_W(MINP_W)) u_min_pulse (
      .clk       (clk),
      .rst_n     (rst_n),
      .d         (gin_q[i]),
      .min_pulse (min_pulse),
      .q_c       (gate_f_c[i])
    );
  end
`else
  logic min_pulse_unused;
  assign min_pulse_unused = ^min_pulse;
  assign gate_f_c         = gin_q;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: faults win over enable; clear is ignored while ext fault persists.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (fault_c) state_d = ST_FAULT;
                   else if (enable) state_d = ST_RUN;
      ST_RUN:      if (fault_c) state_d = ST_FAULT;
                   else if (!enable) state_d = ST_IDLE;
      ST_FAULT:    if (clear && !ext_flt) state_d = ST_COOLDOWN;
      ST_COOLDOWN: if (fault_c) state_d = ST_FAULT;
                   else if (hold_cnt_q == '0) state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    gate_d = '0;
    run_d  = (state_d == ST_RUN);
    code_d = fault_code;
    if (state_d == ST_RUN && !fault_c) begin
      gate_d = gate_f_c;
    end
    if (state_d == ST_FAULT && state_q != ST_FAULT) begin
      if (st_flt && ext_flt) code_d = FC_BOTH;
      else if (st_flt)       code_d = FC_ST;
      else                   code_d = FC_EXT;
    end else if (state_q == ST_COOLDOWN && state_d == ST_IDLE) begin
      code_d = FC_NONE;
    end
  end

  // Output registers and restart holdoff counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_out   <= '0;
      fault_code <= FC_NONE;
      run        <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      gate_out   <= gate_d;
      fault_code <= code_d;
      run        <= run_d;
      if (state_q == ST_FAULT && state_d == ST_COOLDOWN) begin
        hold_cnt_q <= holdoff;
      end else if (state_q == ST_COOLDOWN && hold_cnt_q != '0) begin
        hold_cnt_q <= hold_cnt_q - HOLD_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_gate_fault_guard.sv
// Randomized scoreboard bench for gate_fault_guard. A history-based
// reference model predicts the outputs after each clock edge; a monitor
// compares them at the following falling edge.
module tb_gate_fault_guard;

  localparam int unsigned FILT_W = 4;
  localparam int unsigned HOLD_W = 16;
  localparam int unsigned MINP_W = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_FAULT = 2, S_COOL = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic [5:0]        gate_in = '0;
  logic              fault_n = 1'b1;
  logic [FILT_W-1:0] fault_filt = 4'd4;
  logic [HOLD_W-1:0] holdoff = 16'd100;
  logic [MINP_W-1:0] min_pulse = 5'd5;
  logic              clear = 1'b0;
  logic [5:0]        gate_out;
  logic [1:0]        state;
  logic [1:0]        fault_code;
  logic              run;

  gate_fault_guard #(.FILT_W(FILT_W), .HOLD_W(HOLD_W), .MINP_W(MINP_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .gate_in(gate_in),
    .fault_n(fault_n), .fault_filt(fault_filt), .holdoff(holdoff),
    .min_pulse(min_pulse), .clear(clear), .gate_out(gate_out),
    .state(state), .fault_code(fault_code), .run(run)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [5:0] g;
    logic [1:0] s;
    logic [1:0] c;
    logic       r;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] gh[$];   // gate_in sampled at each edge since reset
  logic       fh[$];   // fault_n sampled at each edge since reset
  int         m_state, cd;
  logic [1:0] m_code;
  int         checks = 0, passed = 0;
  int         cyc = 0;

  task automatic chk(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s @%0t: got %h required %h", name, $time, act, req);
  endtask

  function automatic logic pair_st(input logic [5:0] g);
    return (g[5] && g[4]) || (g[3] && g[2]) || (g[1] && g[0]);
  endfunction

  // External fault is accepted once the N most recent samples that have
  // cleared the two synchronizer stages were all low.
  function automatic logic ext_now();
    int n, idx;
    n = (fault_filt == 0) ? 1 : int'(fault_filt);
    for (int i = 2; i <= n + 1; i++) begin
      idx = fh.size() - 1 - i;
      if (idx < 0) return 1'b0;
      if (fh[idx]) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Registered gates after turn-on filtering: a line is on when it has been
  // high on the last mp+1 captured samples.
  function automatic logic [5:0] filt_now();
    logic [5:0] r;
    int mp, idx;
`ifdef GFG_MIN_PULSE_EN
    mp = int'(min_pulse);
`else
    mp = 0;
`endif
    r = '0;
    for (int b = 0; b < 6; b++) begin
      r[b] = 1'b1;
      for (int j = 0; j <= mp; j++) begin
        idx = gh.size() - 1 - j;
        if (idx < 0) r[b] = 1'b0;
        else if (!gh[idx][b]) r[b] = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    gh.delete();
    fh.delete();
    m_state = S_IDLE;
    m_code  = 2'd0;
    cd      = 0;
  endtask

  // Apply one cycle of inputs and predict the outputs after the next edge.
  task automatic step(input logic en, input logic [5:0] g, input logic fn, input logic clr);
    logic st, ext, flt;
    int   nxt;
    exp_t e;
    enable = en; gate_in = g; fault_n = fn; clear = clr;
    st  = (gh.size() > 0) ? pair_st(gh[gh.size()-1]) : 1'b0;
    ext = ext_now();
    flt = st || ext;
    nxt = m_state;
    case (m_state)
      S_IDLE:  if (flt) nxt = S_FAULT; else if (en) nxt = S_RUN;
      S_RUN:   if (flt) nxt = S_FAULT; else if (!en) nxt = S_IDLE;
      S_FAULT: if (clr && !ext) nxt = S_COOL;
      default: if (flt) nxt = S_FAULT; else if (cd == 0) nxt = S_IDLE;
    endcase
    if (m_state == S_FAULT && nxt == S_COOL) cd = int'(holdoff);
    else if (m_state == S_COOL && nxt == S_COOL) cd--;
    if (nxt == S_FAULT && m_state != S_FAULT) m_code = {st, ext};
    else if (m_state == S_COOL && nxt == S_IDLE) m_code = 2'd0;
    e.g = (nxt == S_RUN && !flt) ? filt_now() : 6'd0;
    e.s = 2'(nxt);
    e.c = m_code;
    e.r = (nxt == S_RUN);
    exp_q.push_back(e);
    m_state = nxt;
    gh.push_back(g);
    fh.push_back(fn);
    if (gh.size() > 64) begin
      void'(gh.pop_front());
      void'(fh.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rnd_valid();
    logic [5:0] g;
    for (int p = 0; p < 3; p++) begin
      case ($urandom_range(0, 2))
        0:       g[2*p +: 2] = 2'b00;
        1:       g[2*p +: 2] = 2'b01;
        default: g[2*p +: 2] = 2'b10;
      endcase
    end
    return g;
  endfunction

  // Monitor: compare every predicted cycle away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cyc++;
        chk($sformatf("cycle %0d {gate,state,code,run}", cyc),
            {gate_out, state, fault_code, run}, e);
      end
    end
  end

  initial begin
    int burst;
    logic fn;
    logic [5:0] g;
    model_reset();
    #5;
    chk("reset outputs", {gate_out, state, fault_code, run}, 11'd0);
    @(negedge clk); #1 rst_n = 1'b1;

    // Normal run with valid complementary patterns.
    repeat (40) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    // Short and long AH pulses.
    repeat (4)  step(1'b1, 6'b100000, 1'b1, 1'b0);
    repeat (6)  step(1'b1, 6'b000000, 1'b1, 1'b0);
    repeat (12) step(1'b1, 6'b100000, 1'b1, 1'b0);
    repeat (6)  step(1'b1, 6'b000000, 1'b1, 1'b0);
    // Single-cycle shoot-through, then clear into a 101-cycle cooldown.
    step(1'b1, 6'b110000, 1'b1, 1'b0);
    repeat (5) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    step(1'b1, rnd_valid(), 1'b1, 1'b1);
    repeat (110) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    // External fault: short burst rejected, long burst accepted.
    repeat (3)  step(1'b1, rnd_valid(), 1'b0, 1'b0);
    repeat (6)  step(1'b1, rnd_valid(), 1'b1, 1'b0);
    repeat (10) step(1'b1, rnd_valid(), 1'b0, 1'b0);
    step(1'b1, rnd_valid(), 1'b0, 1'b1);
    repeat (5) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    // Clear with short holdoff, refault by shoot-through during cooldown.
    holdoff = 16'd3;
    step(1'b1, rnd_valid(), 1'b1, 1'b1);
    step(1'b1, rnd_valid(), 1'b1, 1'b0);
    step(1'b1, 6'b001100, 1'b1, 1'b0);
    repeat (3) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    holdoff = 16'd0;
    step(1'b1, rnd_valid(), 1'b1, 1'b1);
    repeat (6) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    // Shoot-through and filtered external fault land in the same cycle.
    for (int i = 1; i <= 6; i++) step(1'b1, (i == 6) ? 6'b000011 : rnd_valid(), 1'b0, 1'b0);
    repeat (3) step(1'b1, rnd_valid(), 1'b0, 1'b0);
    repeat (5) step(1'b1, rnd_valid(), 1'b1, 1'b0);
    step(1'b1, rnd_valid(), 1'b1, 1'b1);
    repeat (6) step(1'b1, rnd_valid(), 1'b1, 1'b0);

    // Randomized traffic.
    burst = 0;
    for (int n = 0; n < 800; n++) begin
      if (n % 100 == 0) fault_filt = FILT_W'($urandom_range(0, 6));
      holdoff = HOLD_W'($urandom_range(0, 7));
      if (burst > 0) begin
        fn = 1'b0;
        burst--;
      end else begin
        fn = 1'b1;
        if ($urandom_range(0, 29) == 0) burst = $urandom_range(1, 20);
      end
      g = ($urandom_range(0, 39) == 0) ? 6'b110000 : rnd_valid();
      step(($urandom_range(0, 9) != 0), g, fn, ($urandom_range(0, 5) == 0));
    end

    // Back to RUN, then asynchronous reset in the middle of a pulse.
    fault_filt = 4'd4;
    holdoff    = 16'd2;
    repeat (15) step(1'b1, rnd_valid(), 1'b1, 1'b1);
    repeat (3)  step(1'b1, 6'b100001, 1'b1, 1'b0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("async reset outputs", {gate_out, state, fault_code, run}, 11'd0);
    @(posedge clk);
    #1 chk("outputs held in reset", {gate_out, state, fault_code, run}, 11'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (20) step(1'b1, rnd_valid(), 1'b1, 1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/gate_fault_guard.md
# gate_fault_guard

Protection stage between the deadtime driver and the gate-driver pins of the three-phase SPWM inverter. Consumes the six complementary gate signals {AH,AL,BH,BL,CH,CL} and forwards them only while the run state machine is in RUN. Forces all gates off on shoot-through patterns or a filtered external overcurrent fault. Latches the fault cause until an explicit clear, then enforces a restart holdoff.

## Interface

Parameters:
- FILT_W, 4: width of external-fault filter counter
- HOLD_W, 16: width of restart holdoff counter
- MINP_W, 5: width of minimum-pulse counter (used only with GFG_MIN_PULSE_EN)

Ports:
- clk  in  1  system clock, 50 MHz; single clock domain
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  run request, level
- gate_in  in  6  {AH,AL,BH,BL,CH,CL} from deadtime driver; bit 5 = AH
- fault_n  in  1  external overcurrent, active-low, asynchronous to clk
- fault_filt  in  FILT_W  consecutive synchronized low samples needed to accept fault; 0 treated as 1
- holdoff  in  HOLD_W  COOLDOWN length in clk cycles
- min_pulse  in  MINP_W  minimum gate on-time filter, cycles
- clear  in  1  fault acknowledge, sampled in FAULT only
- gate_out  out  6  protected gates, same bit order
- state  out  2  IDLE=0, RUN=1, FAULT=2, COOLDOWN=3
- fault_code  out  2  latched cause: 0 none, 1 external, 2 shoot-through, 3 both
- run  out  1  high when state==RUN

## Operation

- fault_n passes a 2-FF synchronizer; filter counter increments on each synchronized low, clears on high, saturates; ext_flt asserts when count ≥ max(fault_filt,1).
- gate_in is registered into gin_q. st_flt asserts combinationally when any phase pair in gin_q has H=L=1.
- gate_out register loads gin_q only when next state is RUN and neither st_flt nor ext_flt is active; otherwise loads 0. Shoot-through patterns never reach gate_out.
- FSM:
  - IDLE: fault → FAULT; else enable=1 → RUN.
  - RUN: fault → FAULT (priority over enable); enable=0 → IDLE.
  - FAULT: all gates 0; clear=1 with ext_flt=0 → COOLDOWN. clear while ext_flt=1 is ignored.
  - COOLDOWN: counter loads holdoff on entry and decrements. Fault → FAULT. Count reaches 0 → IDLE.
- fault_code: on entry to FAULT, loads {st_flt,ext_flt} of the triggering cycle; both active in the same cycle gives 3. Holds through FAULT and COOLDOWN. Clears to 0 on the COOLDOWN→IDLE transition. A re-fault in COOLDOWN reloads the code.
- Faults are evaluated in IDLE, RUN and COOLDOWN. In IDLE and COOLDOWN the gates are already off, but the fault still latches.

## Timing

- Reset values: gate_out=0, state=IDLE, fault_code=0, run=0; synchronizer and filter are cleared.
- gate_in → gate_out latency is 2 cycles in RUN (GFG_MIN_PULSE_EN off, or min_pulse=0).
- Shoot-through: pattern on gate_in at edge n gives gate_out=0 at edge n+2, and state=FAULT at n+2.
- External fault: fault_n low → ext_flt after 2 sync cycles + max(fault_filt,1) samples; gate_out=0 and state=FAULT on the following edge.
- enable high in IDLE → state=RUN next edge. Gates follow from that edge with the pipeline latency above.
- COOLDOWN lasts holdoff+1 cycles; holdoff=0 gives a single COOLDOWN cycle.
- rst_n assertion mid-operation forces all outputs to their reset values immediately (asynchronous). The latched fault is lost.

## Configuration

- GFG_MIN_PULSE_EN defined: each gate line is delayed on turn-on only. An output rises once its gin_q input has been continuously high for min_pulse cycles. Falling edges pass with no added delay.
  - Input pulses shorter than min_pulse never appear.
  - Rising latency is 2+min_pulse cycles; min_pulse=0 adds no delay.
  - FSM gating still applies after the filter.
- GFG_MIN_PULSE_EN undefined: no filter logic is built. The min_pulse port exists but is ignored. Latency is 2 cycles on both edges.

## Structure

- Shared package gfg_pkg holds:
  - state encodings IDLE/RUN/FAULT/COOLDOWN
  - fault_code constants FC_NONE/FC_EXT/FC_ST/FC_BOTH
  - phase bit-index constants for the 6-bit gate vector
- Sub-module gfg_min_pulse: per-line turn-on delay counter, instantiated 6×. Generated only under GFG_MIN_PULSE_EN.

## Test plan

- Reset, enable=1, gate_in toggling valid complementary patterns → state=RUN after 1 cycle; gate_out equals gate_in delayed 2 cycles; fault_code=0.
- In RUN drive gate_in=6'b110000 (AH=AL=1) for 1 cycle → gate_out never shows 110000; gate_out=0 and state=FAULT 2 cycles later; fault_code=2.
- fault_filt=4: fault_n low for 3 cycles, then low for 10 cycles → first burst no fault; second gives FAULT at 2+4+1 cycles, fault_code=1.
- In FAULT, pulse clear with fault_n still low → stays FAULT. Release fault_n, clear again with holdoff=100 → COOLDOWN for 101 cycles, then IDLE, fault_code=0, then RUN.
- Shoot-through and filtered external fault in the same cycle → fault_code=3. Refault during COOLDOWN → back to FAULT with reloaded code.
- With GFG_MIN_PULSE_EN, min_pulse=5:
  - AH pulse of 4 cycles → suppressed.
  - AH pulse of 12 cycles → gate_out AH high for 7 cycles, falling edge 2 cycles after input.
  - Assert rst_n low mid-pulse → all outputs 0 immediately.
